trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Sequences trap entry (synchronous exceptions and machine interrupts) and MRET return for the multicycle core datapath.
- Prioritises pending interrupts and latches the cause code.
- Drives the datapath's trap-path mux selects (pc, mepc, mcause, mtval, mie, mpie) for one cycle.
- Sits beside the main control unit. While trap_active=1, the control unit forwards this block's select values to the datapath instead of its own.

Parameters:
- MIN_RETIRE, 1, instructions that must retire after a trap entry or MRET before another interrupt may be taken (forward-progress guarantee); 0 disables the guard.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_boundary  in  1  core is in instruction-fetch state and no instruction is in flight
- instr_retired  in  1  one instruction retired this cycle
- exc_valid  in  1  control unit detected a synchronous exception this cycle
- exc_cause  in  5  exception mcause code, bit4=0
- exc_tval_sel  in  3  mtval_next_sel value for this exception
- mret_valid  in  1  MRET executing this cycle
- mie, mtie, msie, meie  in  1 each  current CSR enable bits
- mtip, msip, meip  in  1 each  raw interrupt-pending lines
- squash  out  1  control unit must hold pc (pc_next_sel=3) and suppress reg_we and memory writes this cycle
- trap_active  out  1  selects below override the control unit's values
- trap_taken  out  1  one-cycle pulse in the trap-entry cycle
- pc_next_sel  out  2  0 adder, 1 mtvec, 2 mepc, 3 pc
- mepc_next_sel  out  1  0 csr, 1 pc
- mcause_next_sel  out  1  0 csr, 1 control unit
- mcause_next  out  5  {interrupt, code[3:0]}
- mtval_next_sel  out  3  0 csr, 1 pc, 2 mem_addr, 3 instr, 4 zero
- mie_next_sel  out  2  0 csr, 1 zero, 2 mpie
- mpie_next_sel  out  2  0 csr, 1 mie, 2 one

Behaviour:
- Interrupt sampling: irq_q <= {meip&meie, msip&msie, mtip&mtie}, registered every cycle, so there is 1 cycle of sampling latency. Interrupts are level-sensitive; no pending state is held beyond irq_q.
- Interrupt priority: MEI (code 11) > MSI (code 3) > MTI (code 7). Interrupt mcause = {1'b1, code}.
- Retire counter ret_cnt, width $clog2(MIN_RETIRE+1):
  - saturates at MIN_RETIRE;
  - increments on instr_retired;
  - cleared to 0 on every entry to ENTRY or MRET;
  - reset value MIN_RETIRE.
- irq_ok = instr_boundary & mie & |irq_q & (ret_cnt == MIN_RETIRE).
- FSM states: RUN, ENTRY, RET. Reset state is RUN.
- RUN, decisions in priority order (exception > interrupt > MRET):
  - exc_valid: latch cause_q=exc_cause and tval_q=exc_tval_sel, squash=1 (combinational), go to ENTRY.
  - else irq_ok: latch cause_q=interrupt cause and tval_q=4, squash=1, go to ENTRY.
  - else mret_valid: squash=0, go to RET.
  - otherwise stay in RUN with squash=0.
- ENTRY (exactly 1 cycle): trap_active=1, trap_taken=1, pc_next_sel=1, mepc_next_sel=1, mcause_next_sel=1, mcause_next=cause_q, mtval_next_sel=tval_q, mie_next_sel=1, mpie_next_sel=1, squash=1. Go to RUN.
- RET (exactly 1 cycle): trap_active=1, pc_next_sel=2, mie_next_sel=2, mpie_next_sel=2, other selects 0, squash=1. Go to RUN.
- Outputs in RUN and after reset: trap_active=0, trap_taken=0, all selects 0, mcause_next=0. squash follows the RUN rules above.
- Latency:
  - exception: detect cycle, then ENTRY; pc = mtvec on the following edge (2 edges).
  - interrupt: line rises, irq_q one edge later, decision at the next instr_boundary, then ENTRY.
- mepc captures the pc still held by the squash cycle: the faulting instruction for exceptions, the next unfetched instruction for interrupts.
- Boundary conditions:
  - exc_valid or mret_valid while in ENTRY/RET: ignored.
  - Interrupt dropping before the decision cycle: not taken.
  - Reset mid-ENTRY or mid-RET: next state RUN, outputs at reset values, no CSR write selected.
  - mie=0 masks all interrupts; exceptions are never masked.

Test Plan:
- meie=1, mie=1, meip raised, instr_boundary=1 held, ret_cnt saturated → squash on cycle 2, ENTRY on cycle 3 with mcause_next=5'h1B, mtval_next_sel=4, pc_next_sel=1, mie_next_sel=1, mpie_next_sel=1, trap_taken pulse of 1 cycle.
- meip, msip and mtip all pending and enabled → mcause_next=5'h1B; drop meip → 5'h13; drop msip → 5'h17.
- exc_valid=1, exc_cause=5'h02, exc_tval_sel=3, with msip also pending at a boundary → ENTRY with mcause_next=5'h02, mtval_next_sel=3; the interrupt is not taken that cycle.
- mret_valid pulse → RET cycle with pc_next_sel=2, mie_next_sel=2, mpie_next_sel=2. With mtip still pending and MIN_RETIRE=1, no ENTRY until one instr_retired pulse, then ENTRY at the next boundary.
- mie=0 with all interrupts pending for 20 cycles → never ENTRY. Set mie=1 → ENTRY within 2 cycles at a boundary.
- Assert reset during ENTRY → next cycle trap_active=0, all selects 0, state RUN, ret_cnt=MIN_RETIRE.

Source files
------------

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Sequences trap entry (synchronous exceptions and machine
//               interrupts) and MRET return for the multicycle core. While
//               trap_active is high, the control unit forwards the CSR/PC
//               select values below to the datapath instead of its own.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr_boundary      core is at instruction fetch with nothing in flight
//   instr_retired       one instruction retired this cycle
//   exc_valid/cause     synchronous exception detected, its mcause code
//   exc_tval_sel        mtval_next_sel value to use for that exception
//   mret_valid          MRET executing this cycle
//   mie,mtie,msie,meie  CSR enable bits
//   mtip,msip,meip      raw interrupt-pending lines
//   squash              hold pc, suppress reg/memory writes this cycle
//   trap_active         override the control unit's selects
//   trap_taken          one-cycle pulse in the trap-entry cycle
//   *_next_sel          datapath mux selects for pc/mepc/mcause/mtval/mie/mpie
//   mcause_next         {interrupt, code[3:0]}
//
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
    parameter int MIN_RETIRE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_boundary,
    input  logic       instr_retired,
    input  logic       exc_valid,
    input  logic [4:0] exc_cause,
    input  logic [2:0] exc_tval_sel,
    input  logic       mret_valid,
    input  logic       mie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meie,
    input  logic       mtip,
    input  logic       msip,
    input  logic       meip,
    output logic       squash,
    output logic       trap_active,
    output logic       trap_taken,
    output logic [1:0] pc_next_sel,
    output logic       mepc_next_sel,
    output logic       mcause_next_sel,
    output logic [4:0] mcause_next,
    output logic [2:0] mtval_next_sel,
    output logic [1:0] mie_next_sel,
    output logic [1:0] mpie_next_sel
);

    // A zero-width counter is illegal, so MIN_RETIRE=0 still gets one bit;
    // the counter then simply stays at 0, which equals the saturation value.
    localparam int                 c_CNT_W   = (MIN_RETIRE > 0) ? $clog2(MIN_RETIRE + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MIN_RETIRE);
    localparam logic [2:0]         c_TVAL_ZERO = 3'd4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_ENTRY = 2'd1,
        S_RET   = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_irq_q;      // {MEI, MSI, MTI}, pending & enabled
    logic [c_CNT_W-1:0] r_ret_cnt;
    logic [4:0]         r_cause_q;    // doubles as the registered mcause_next
    logic [2:0]         r_tval_q;     // doubles as the registered mtval_next_sel
    logic               r_trap_active;
    logic               r_trap_taken;
    logic [1:0]         r_pc_next_sel;
    logic               r_mepc_next_sel;
    logic               r_mcause_next_sel;
    logic [1:0]         r_mie_next_sel;
    logic [1:0]         r_mpie_next_sel;

    logic [4:0]         w_irq_cause;
    logic               w_irq_ok;
    logic [c_CNT_W-1:0] w_ret_cnt_inc;

    // Fixed priority MEI > MSI > MTI on the sampled lines.
    always_comb begin
        w_irq_cause = 5'h00;
        if (r_irq_q[2]) begin
            w_irq_cause = {1'b1, 4'd11};
        end else if (r_irq_q[1]) begin
            w_irq_cause = {1'b1, 4'd3};
        end else if (r_irq_q[0]) begin
            w_irq_cause = {1'b1, 4'd7};
        end
    end

    // Interrupts are only taken at an instruction boundary and only once
    // enough instructions have retired since the last trap entry / MRET.
    assign w_irq_ok = instr_boundary & mie & (|r_irq_q) & (r_ret_cnt == c_CNT_MAX);

    assign w_ret_cnt_inc = (instr_retired && (r_ret_cnt != c_CNT_MAX))
                         ? r_ret_cnt + c_CNT_W'(1) : r_ret_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_RUN;
            r_irq_q           <= 3'b000;
            r_ret_cnt         <= c_CNT_MAX;
            r_cause_q         <= 5'h00;
            r_tval_q          <= 3'd0;
            r_trap_active     <= 1'b0;
            r_trap_taken      <= 1'b0;
            r_pc_next_sel     <= 2'd0;
            r_mepc_next_sel   <= 1'b0;
            r_mcause_next_sel <= 1'b0;
            r_mie_next_sel    <= 2'd0;
            r_mpie_next_sel   <= 2'd0;
        end else begin
            r_irq_q <= {meip & meie, msip & msie, mtip & mtie};

            // Outputs default to the RUN values; the entering transition
            // overrides them so they are valid throughout ENTRY/RET.
            r_cause_q         <= 5'h00;
            r_tval_q          <= 3'd0;
            r_trap_active     <= 1'b0;
            r_trap_taken      <= 1'b0;
            r_pc_next_sel     <= 2'd0;
            r_mepc_next_sel   <= 1'b0;
            r_mcause_next_sel <= 1'b0;
            r_mie_next_sel    <= 2'd0;
            r_mpie_next_sel   <= 2'd0;
            r_ret_cnt         <= w_ret_cnt_inc;

            case (r_state)
                S_RUN: begin
                    if (exc_valid || w_irq_ok) begin
                        r_state           <= S_ENTRY;
                        r_ret_cnt         <= '0;
                        r_cause_q         <= exc_valid ? exc_cause : w_irq_cause;
                        r_tval_q          <= exc_valid ? exc_tval_sel : c_TVAL_ZERO;
                        r_trap_active     <= 1'b1;
                        r_trap_taken      <= 1'b1;
                        r_pc_next_sel     <= 2'd1;
                        r_mepc_next_sel   <= 1'b1;
                        r_mcause_next_sel <= 1'b1;
                        r_mie_next_sel    <= 2'd1;
                        r_mpie_next_sel   <= 2'd1;
                    end else if (mret_valid) begin
                        r_state         <= S_RET;
                        r_ret_cnt       <= '0;
                        r_trap_active   <= 1'b1;
                        r_pc_next_sel   <= 2'd2;
                        r_mie_next_sel  <= 2'd2;
                        r_mpie_next_sel <= 2'd2;
                    end
                end
                S_ENTRY: r_state <= S_RUN;
                S_RET:   r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

    // In RUN the squash must appear in the decision cycle itself so the
    // faulting (or next unfetched) pc is still held when mepc captures it.
    assign squash = r_trap_active |
                    ((r_state == S_RUN) & (exc_valid | w_irq_ok));

    assign trap_active     = r_trap_active;
    assign trap_taken      = r_trap_taken;
    assign pc_next_sel     = r_pc_next_sel;
    assign mepc_next_sel   = r_mepc_next_sel;
    assign mcause_next_sel = r_mcause_next_sel;
    assign mcause_next     = r_cause_q;
    assign mtval_next_sel  = r_tval_q;
    assign mie_next_sel    = r_mie_next_sel;
    assign mpie_next_sel   = r_mpie_next_sel;

endmodule
`default_nettype wire
